risc_control_fsm: RTL and testbench



---
 rtl/risc_control_fsm_pkg.sv | 66 ++++++
 rtl/risc_control_fsm.sv | 116 +++++++++++
 tb/tb_risc_control_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/risc_control_fsm_pkg.sv
// Shared encodings for the RISC control FSM: state codes, control field
// constants and the decode vector layout.
package risc_control_fsm_pkg;

  localparam int SW = 6;

  typedef enum logic [SW-1:0] {
    SReset, SIF1, SIF2, SUpdatePC, SDecode,
    Sa, Sb, Sc, Sd,
    SMovA1, SMovB1, SMovB2, SMovB3,
    SAnd1, SAnd2, SAnd3, SAnd4,
    Scmp1, Scmp2, Scmp3,
    Smvn1, Smvn2, Smvn3, Smvn4,
    LDR1, LDR2, LDR3, LDR4,
    STR1, STR2, STR3, STR4, STR5,
    HALT
  } state_e;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  localparam logic [3:0] VSEL_MDATA = 4'b1000;
  localparam logic [3:0] VSEL_C     = 4'b0100;
  localparam logic [3:0] VSEL_IMM   = 4'b0010;
  localparam logic [3:0] VSEL_PC    = 4'b0001;

  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_NONE = 3'b000;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  // 27-bit decode vector, MSB first
  typedef struct packed {
    state_e     next_state;
    logic       reset_pc;
    logic       load_pc;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       load_ir;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic [3:0] vsel;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       loads;
    logic       load_addr;
  } ctrl_t;

endpackage

// File: rtl/risc_control_fsm.sv
// Moore controller for the simple RISC CPU: fetch, PC update, decode and
// per-instruction multi-cycle execute, all outputs decoded from present state.
module risc_control_fsm
  import risc_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       load_ir,
  output logic       addr_sel,
  output logic       load_pc,
  output logic       reset_pc,
  output logic [1:0] mem_cmd,
  output logic [3:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] nsel,
  output logic       load_addr
);

  state_e state_q, state_d;
  ctrl_t  d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SReset;
    else        state_q <= state_d;
  end

  always_comb begin
    d            = '0;
    d.vsel       = VSEL_C;
    d.nsel       = NSEL_NONE;
    d.next_state = SReset;
    unique case (state_q)
      SReset:    begin d.reset_pc = 1'b1; d.load_pc = 1'b1; d.next_state = SIF1; end
      SIF1:      begin d.addr_sel = 1'b1; d.mem_cmd = MEM_RD; d.next_state = SIF2; end
      SIF2:      begin
        d.addr_sel = 1'b1; d.mem_cmd = MEM_RD; d.load_ir = 1'b1; d.next_state = SUpdatePC;
      end
      SUpdatePC: begin d.load_pc = 1'b1; d.next_state = SDecode; end
      SDecode: begin
        casez ({opcode, op})
          {OPC_MOV, OP_MOVI}: d.next_state = SMovA1;
          {OPC_MOV, OP_MOVR}: d.next_state = SMovB1;
          {OPC_ALU, OP_ADD}:  d.next_state = Sa;
          {OPC_ALU, OP_CMP}:  d.next_state = Scmp1;
          {OPC_ALU, OP_AND}:  d.next_state = SAnd1;
          {OPC_ALU, OP_MVN}:  d.next_state = Smvn1;
          {OPC_LDR, 2'b??}:   d.next_state = LDR1;
          {OPC_STR, 2'b??}:   d.next_state = STR1;
          {OPC_HALT, 2'b??}:  d.next_state = HALT;
          default:            d.next_state = SIF1;
        endcase
      end
      SMovA1: begin d.nsel = NSEL_RN; d.vsel = VSEL_IMM; d.write = 1'b1; d.next_state = SIF1; end
      SMovB1: begin d.nsel = NSEL_RM; d.loadb = 1'b1; d.next_state = SMovB2; end
      SMovB2: begin d.asel = 1'b1; d.loadc = 1'b1; d.next_state = SMovB3; end
      SMovB3: begin d.nsel = NSEL_RD; d.write = 1'b1; d.next_state = SIF1; end
      // ADD, AND and MVN share the same four-step A/B/C/write-back pattern
      Sa, SAnd1, Smvn1: begin
        d.nsel = NSEL_RN; d.loada = 1'b1;
        d.next_state = (state_q == Sa) ? Sb : (state_q == SAnd1) ? SAnd2 : Smvn2;
      end
      Sb, SAnd2, Smvn2: begin
        d.nsel = NSEL_RM; d.loadb = 1'b1;
        d.next_state = (state_q == Sb) ? Sc : (state_q == SAnd2) ? SAnd3 : Smvn3;
      end
      Sc, SAnd3, Smvn3: begin
        d.loadc = 1'b1;
        d.next_state = (state_q == Sc) ? Sd : (state_q == SAnd3) ? SAnd4 : Smvn4;
      end
      Sd, SAnd4, Smvn4: begin d.nsel = NSEL_RD; d.write = 1'b1; d.next_state = SIF1; end
      Scmp1: begin d.nsel = NSEL_RN; d.loada = 1'b1; d.next_state = Scmp2; end
      Scmp2: begin d.nsel = NSEL_RM; d.loadb = 1'b1; d.next_state = Scmp3; end
      Scmp3: begin d.loads = 1'b1; d.next_state = SIF1; end
      LDR1:  begin d.nsel = NSEL_RN; d.loada = 1'b1; d.next_state = LDR2; end
      LDR2:  begin d.bsel = 1'b1; d.loadc = 1'b1; d.next_state = LDR3; end
      LDR3:  begin d.load_addr = 1'b1; d.next_state = LDR4; end
      LDR4:  begin
        d.mem_cmd = MEM_RD; d.nsel = NSEL_RD; d.vsel = VSEL_MDATA; d.write = 1'b1;
        d.next_state = SIF1;
      end
      STR1:  begin d.nsel = NSEL_RN; d.loada = 1'b1; d.next_state = STR2; end
      STR2:  begin d.bsel = 1'b1; d.loadc = 1'b1; d.next_state = STR3; end
      STR3:  begin d.load_addr = 1'b1; d.nsel = NSEL_RD; d.loadb = 1'b1; d.next_state = STR4; end
      STR4:  begin d.asel = 1'b1; d.loadc = 1'b1; d.next_state = STR5; end
      STR5:  begin d.mem_cmd = MEM_WR; d.next_state = SIF1; end
      HALT:  d.next_state = HALT;
      default: d.next_state = SReset;
    endcase
  end

  assign state_d   = d.next_state;
  assign reset_pc  = d.reset_pc;
  assign load_pc   = d.load_pc;
  assign addr_sel  = d.addr_sel;
  assign mem_cmd   = d.mem_cmd;
  assign load_ir   = d.load_ir;
  assign nsel      = d.nsel;
  assign loada     = d.loada;
  assign loadb     = d.loadb;
  assign loadc     = d.loadc;
  assign vsel      = d.vsel;
  assign asel      = d.asel;
  assign bsel      = d.bsel;
  assign write     = d.write;
  assign loads     = d.loads;
  assign load_addr = d.load_addr;

endmodule

// File: tb/tb_risc_control_fsm.sv
// Directed bench for risc_control_fsm: walks every instruction path and checks
// the full Moore output vector in each state against hand-built constants.
module tb_risc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       load_ir, addr_sel, load_pc, reset_pc, write;
  logic       loada, loadb, loadc, loads, asel, bsel, load_addr;
  logic [1:0] mem_cmd;
  logic [3:0] vsel;
  logic [2:0] nsel;

  int n_checks = 0;
  int n_fail   = 0;

  risc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .load_ir(load_ir), .addr_sel(addr_sel), .load_pc(load_pc), .reset_pc(reset_pc),
    .mem_cmd(mem_cmd), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .nsel(nsel), .load_addr(load_addr)
  );

  always #5 clk = ~clk;

  // Observed vector: {reset_pc, load_pc, addr_sel, mem_cmd, load_ir, nsel,
  //                   loada, loadb, loadc, vsel, asel, bsel, write, loads, load_addr}
  logic [20:0] obs;
  assign obs = {reset_pc, load_pc, addr_sel, mem_cmd, load_ir, nsel,
                loada, loadb, loadc, vsel, asel, bsel, write, loads, load_addr};

  localparam logic [20:0] RPC  = 21'd1 << 20;
  localparam logic [20:0] LPC  = 21'd1 << 19;
  localparam logic [20:0] APC  = 21'd1 << 18;
  localparam logic [20:0] MWR  = 21'd1 << 17;
  localparam logic [20:0] MRD  = 21'd1 << 16;
  localparam logic [20:0] LIR  = 21'd1 << 15;
  localparam logic [20:0] NRN  = 21'd1 << 14;
  localparam logic [20:0] NRD  = 21'd1 << 13;
  localparam logic [20:0] NRM  = 21'd1 << 12;
  localparam logic [20:0] LA   = 21'd1 << 11;
  localparam logic [20:0] LB   = 21'd1 << 10;
  localparam logic [20:0] LC   = 21'd1 << 9;
  localparam logic [20:0] AS   = 21'd1 << 4;
  localparam logic [20:0] BS   = 21'd1 << 3;
  localparam logic [20:0] WR   = 21'd1 << 2;
  localparam logic [20:0] LS   = 21'd1 << 1;
  localparam logic [20:0] LADR = 21'd1;

  function automatic logic [20:0] ex(input logic [20:0] flags, input logic [3:0] vs);
    return flags | ({17'd0, vs} << 5);
  endfunction

  localparam logic [3:0] VC = 4'b0100;
  logic [20:0] E_RST, E_IF1, E_IF2, E_UPC, E_DEC, E_S1, E_S2, E_LC, E_WB;
  logic [20:0] E_MOVA, E_MOVB2, E_CMP3, E_LDR2, E_LDR3, E_LDR4, E_STR3, E_STR4, E_STR5;

  logic [20:0] seq [8];

  task automatic chk(input string tag, input logic [20:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      $error("%s observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic step(input string tag, input logic [20:0] exp_v);
    @(posedge clk); #1;
    chk(tag, exp_v);
  endtask

  // Assumes SIF1 has just been checked; walks to SDecode with the given IR fields.
  task automatic to_decode(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc; op = o;
    step("SIF2", E_IF2);
    step("SUpdatePC", E_UPC);
    step("SDecode", E_DEC);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, seq[i]);
    step({tag, "->SIF1"}, E_IF1);
  endtask

  initial begin
    E_RST = ex(RPC | LPC, VC);      E_IF1 = ex(APC | MRD, VC);
    E_IF2 = ex(APC | MRD | LIR, VC); E_UPC = ex(LPC, VC);
    E_DEC = ex('0, VC);             E_S1  = ex(NRN | LA, VC);
    E_S2  = ex(NRM | LB, VC);       E_LC  = ex(LC, VC);
    E_WB  = ex(NRD | WR, VC);       E_MOVA = ex(NRN | WR, 4'b0010);
    E_MOVB2 = ex(AS | LC, VC);      E_CMP3 = ex(LS, VC);
    E_LDR2 = ex(BS | LC, VC);       E_LDR3 = ex(LADR, VC);
    E_LDR4 = ex(MRD | NRD | WR, 4'b1000);
    E_STR3 = ex(LADR | NRD | LB, VC);
    E_STR4 = ex(AS | LC, VC);       E_STR5 = ex(MWR, VC);

    reset = 1'b0; opcode = 3'b000; op = 2'b00;
    #2 chk("reset_held", E_RST);
    step("reset_held_edge", E_RST);
    reset = 1'b1;
    step("SIF1", E_IF1);

    // ADD, interrupted by reset in Sb
    to_decode(3'b101, 2'b00);
    step("Sa", E_S1);
    step("Sb", E_S2);
    #2 reset = 1'b0;
    #1 chk("async_reset_in_Sb", E_RST);
    #2 reset = 1'b1;
    step("SIF1_after_reset", E_IF1);

    // MVN
    to_decode(3'b101, 2'b11);
    seq[0] = E_S1; seq[1] = E_S2; seq[2] = E_LC; seq[3] = E_WB;
    run("MVN", 4);

    // MOV immediate
    to_decode(3'b110, 2'b10);
    seq[0] = E_MOVA;
    run("MOVI", 1);

    // MOV register
    to_decode(3'b110, 2'b00);
    seq[0] = E_S2; seq[1] = E_MOVB2; seq[2] = E_WB;
    run("MOVR", 3);

    // CMP
    to_decode(3'b101, 2'b01);
    seq[0] = E_S1; seq[1] = E_S2; seq[2] = E_CMP3;
    run("CMP", 3);

    // AND
    to_decode(3'b101, 2'b10);
    seq[0] = E_S1; seq[1] = E_S2; seq[2] = E_LC; seq[3] = E_WB;
    run("AND", 4);

    // ADD uninterrupted
    to_decode(3'b101, 2'b00);
    run("ADD", 4);

    // LDR, op bits are don't-care
    to_decode(3'b011, 2'b01);
    seq[0] = E_S1; seq[1] = E_LDR2; seq[2] = E_LDR3; seq[3] = E_LDR4;
    run("LDR", 4);

    // STR
    to_decode(3'b100, 2'b11);
    seq[0] = E_S1; seq[1] = E_LDR2; seq[2] = E_STR3; seq[3] = E_STR4; seq[4] = E_STR5;
    run("STR", 5);

    // Unassigned opcode falls back to fetch
    to_decode(3'b000, 2'b10);
    step("undef_opcode->SIF1", E_IF1);
    to_decode(3'b110, 2'b01);
    step("undef_mov_op->SIF1", E_IF1);

    // HALT sticks until reset
    to_decode(3'b111, 2'b00);
    step("HALT", E_DEC);
    opcode = 3'b101; op = 2'b00;
    for (int i = 0; i < 10; i++) step("HALT_hold", E_DEC);
    #2 reset = 1'b0;
    #1 chk("reset_from_HALT", E_RST);
    #2 reset = 1'b1;
    step("SIF1_after_HALT", E_IF1);
    step("SIF2_after_HALT", E_IF2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
